// File: rtl/pwm_core.sv
// Two-channel PWM timer core.
// Counter runs edge-aligned (0..P, wrap) or center-aligned (0..P..1, wrap),
// advanced by a prescaler tick. Mode, period, duties and divider live in
// shadow registers that reload only on an update event, so a period in
// progress always finishes with the settings it started with.

// Per-channel compare: holds the channel's shadow duty and the registered
// PWM output (cnt < duty, one clock behind cnt).
module pwm_chan #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,   // shadow reload strobe
    input  logic             clear,  // force output low (IDLE / stopping)
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm
);

    logic [WIDTH-1:0] sh_duty;

    // Shadow duty reload and registered unsigned compare; the compare uses the
    // shadow value that was current for the cnt being compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_duty <= '0;
            pwm     <= 1'b0;
        end else begin
            if (load)
                sh_duty <= duty;
            if (clear)
                pwm <= 1'b0;
            else
                pwm <= (cnt < sh_duty);
        end
    end

endmodule

module pwm_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty1,
    input  logic [WIDTH-1:0] duty2,
    input  logic [WIDTH-1:0] prescaler_div,
    output logic             pwm1,
    output logic             pwm2,
    output logic [WIDTH-1:0] cnt,
    output logic             dir,
    output logic             uev,
    output logic             running
);

    localparam int NUM_CH = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic             sh_mode;
    logic [WIDTH-1:0] sh_period;
    logic [WIDTH-1:0] sh_div;
    logic [WIDTH-1:0] psc;

    logic             tick;
    logic             evt;
    logic             dir_nxt;
    logic [WIDTH-1:0] cnt_nxt;

    logic             ch_load;
    logic             ch_clear;

    logic [NUM_CH-1:0][WIDTH-1:0] duty_v;
    logic [NUM_CH-1:0]            pwm_v;

    assign duty_v = {duty2, duty1};
    assign pwm1   = pwm_v[0];
    assign pwm2   = pwm_v[1];

    // Prescaler tick: divider 0 means a tick on every clock.
    assign tick = (psc == sh_div);

    // Next counter value/direction and update-event detection for one tick.
    // The down-count test uses <= 1 so a cnt of 0 while counting down (not
    // reachable) can never underflow.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        evt     = 1'b0;
        if (tick) begin
            if (!sh_mode) begin
                dir_nxt = 1'b0;
                if (cnt == sh_period) begin
                    cnt_nxt = '0;
                    evt     = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (!dir) begin
                if (cnt == sh_period) begin
                    if (sh_period >= WIDTH'(2)) begin
                        dir_nxt = 1'b1;
                        cnt_nxt = sh_period - 1'b1;
                    end else begin
                        cnt_nxt = '0;
                        evt     = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                if (cnt <= WIDTH'(1)) begin
                    cnt_nxt = '0;
                    dir_nxt = 1'b0;
                    evt     = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
        end
    end

    // Channel shadows load on start-up and on every update event; outputs
    // are held low whenever the core is not actively running.
    assign ch_load  = en && ((state == IDLE) || evt);
    assign ch_clear = !((state == RUN) && en);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            pwm_chan #(.WIDTH(WIDTH)) u_chan (
                .clk   (clk),
                .rst   (rst),
                .load  (ch_load),
                .clear (ch_clear),
                .cnt   (cnt),
                .duty  (duty_v[i]),
                .pwm   (pwm_v[i])
            );
        end
    endgenerate

    // IDLE/RUN controller: owns counter, prescaler, direction, uev and shadows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dir       <= 1'b0;
            uev       <= 1'b0;
            running   <= 1'b0;
            psc       <= '0;
            sh_mode   <= 1'b0;
            sh_period <= '0;
            sh_div    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    dir <= 1'b0;
                    uev <= 1'b0;
                    psc <= '0;
                    if (en) begin
                        sh_mode   <= mode;
                        sh_period <= period;
                        sh_div    <= prescaler_div;
                        running   <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        cnt     <= '0;
                        dir     <= 1'b0;
                        uev     <= 1'b0;
                        psc     <= '0;
                        running <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        psc <= tick ? '0 : psc + 1'b1;
                        cnt <= cnt_nxt;
                        dir <= dir_nxt;
                        uev <= evt;
                        if (evt) begin
                            sh_mode   <= mode;
                            sh_period <= period;
                            sh_div    <= prescaler_div;
                            // A switch to edge-aligned must never inherit a down count.
                            if (!mode)
                                dir <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_core.sv
// Scoreboard bench for pwm_core: stimulus pushes the expected post-edge
// outputs; a negedge monitor pops and compares them.
module tb_pwm_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, en, mode;
    logic [W-1:0] period, duty1, duty2, prescaler_div;
    logic         pwm1, pwm2, dir, uev, running;
    logic [W-1:0] cnt;

    always #5 clk = ~clk;

    pwm_core #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .mode          (mode),
        .period        (period),
        .duty1         (duty1),
        .duty2         (duty2),
        .prescaler_div (prescaler_div),
        .pwm1          (pwm1),
        .pwm2          (pwm2),
        .cnt           (cnt),
        .dir           (dir),
        .uev           (uev),
        .running       (running)
    );

    typedef struct {
        logic [W-1:0] cnt;
        logic         pwm1;
        logic         pwm2;
        logic         uev;
        logic         running;
        logic         dir;
        string        nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   seq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    // Monitor: compare each expected record against the settled outputs.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (cnt !== e.cnt || pwm1 !== e.pwm1 || pwm2 !== e.pwm2 ||
                uev !== e.uev || running !== e.running || dir !== e.dir) begin
                errors++;
                $display("FAIL %s @%0t: got cnt=%0d pwm1=%b pwm2=%b uev=%b run=%b dir=%b, want cnt=%0d pwm1=%b pwm2=%b uev=%b run=%b dir=%b",
                         e.nm, $time, cnt, pwm1, pwm2, uev, running, dir,
                         e.cnt, e.pwm1, e.pwm2, e.uev, e.running, e.dir);
            end
        end
    end

    // Advance one clock and queue the outputs expected after that edge.
    task automatic step(input logic [W-1:0] c, input logic p1, input logic p2,
                        input logic u, input logic r, input logic d, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.cnt = c; e.pwm1 = p1; e.pwm2 = p2; e.uev = u; e.running = r; e.dir = d; e.nm = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0;
        period = 16'd9; duty1 = 16'd3; duty2 = 16'd10; prescaler_div = 16'd0;
        step(0, 0, 0, 0, 0, 0, "reset");
        en = 1'b1;
        step(0, 0, 0, 0, 0, 0, "reset_over_en");

        // Edge mode P=9 D1=3 D2=10; D1 changed to 6 mid-period at edge 33
        rst = 1'b0;
        step(0, 0, 0, 0, 1, 0, "edge_start");
        for (int j = 1; j <= 65; j++) begin
            if (j == 33) duty1 = 16'd6;
            step(W'(j % 10), ((j - 1) % 10) < (((j - 1) < 40) ? 3 : 6), 1'b1,
                 (j % 10) == 0, 1'b1, 1'b0, "edge_run");
        end

        // en dropped with cnt=5, then restart
        en = 1'b0;
        step(0, 0, 0, 0, 0, 0, "en_drop");
        step(0, 0, 0, 0, 0, 0, "idle_hold");
        en = 1'b1;
        step(0, 0, 0, 0, 1, 0, "restart");
        for (int j = 1; j <= 12; j++)
            step(W'(j % 10), ((j - 1) % 10) < 6, 1'b1, (j % 10) == 0, 1'b1, 1'b0, "restart_run");

        // rst pulsed mid-run with en held
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, "rst_mid");
        rst = 1'b0;
        step(0, 0, 0, 0, 1, 0, "rst_release");
        for (int j = 1; j <= 5; j++)
            step(W'(j % 10), ((j - 1) % 10) < 6, 1'b1, 1'b0, 1'b1, 1'b0, "post_rst");

        // Center mode P=4 D1=2 D2=0
        en = 1'b0;
        step(0, 0, 0, 0, 0, 0, "to_idle_c");
        mode = 1'b1; period = 16'd4; duty1 = 16'd2; duty2 = 16'd0; en = 1'b1;
        step(0, 0, 0, 0, 1, 0, "center_start");
        for (int j = 1; j <= 24; j++) begin
            int idx, pidx;
            idx = j % 8;
            pidx = (j - 1) % 8;
            step(W'(seq[idx]), seq[pidx] < 2, 1'b0, idx == 0, 1'b1, idx >= 5, "center");
        end

        // Edge mode with prescaler: P=3 div=2 D1=2 D2=4
        en = 1'b0;
        step(0, 0, 0, 0, 0, 0, "to_idle_p");
        mode = 1'b0; period = 16'd3; duty1 = 16'd2; duty2 = 16'd4; prescaler_div = 16'd2; en = 1'b1;
        step(0, 0, 0, 0, 1, 0, "psc_start");
        for (int j = 1; j <= 26; j++)
            step(W'((j / 3) % 4), (((j - 1) / 3) % 4) < 2, 1'b1, (j % 12) == 0, 1'b1, 1'b0, "psc");

        // P=0: uev every tick; then mode/period change via reload to center P=1
        en = 1'b0;
        step(0, 0, 0, 0, 0, 0, "to_idle_z");
        period = 16'd0; duty1 = 16'd0; duty2 = 16'd1; prescaler_div = 16'd0; en = 1'b1;
        step(0, 0, 0, 0, 1, 0, "p0_start");
        for (int j = 1; j <= 4; j++)
            step(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "p0");
        mode = 1'b1; period = 16'd1;
        step(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "p0_reload");
        for (int k = 1; k <= 6; k++)
            step(W'(k % 2), 1'b0, (k % 2) == 1, (k % 2) == 0, 1'b1, 1'b0, "p1_center");

        en = 1'b0;
        step(0, 0, 0, 0, 0, 0, "final_idle");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion by %0t, want completion", $time);
        $fatal(1, "timeout");
    end

endmodule
